// File: rtl/midi_encoder_if.sv
// Message handshake between the sequencer/control logic (master) and the MIDI encoder (slave).
//   msg_valid  master -> slave  message on msg_byte0..2 is valid
//   msg_ready  slave  -> master encoder can accept a message this cycle
//   msg_byte0  master -> slave  status byte (bit7 must be 1)
//   msg_byte1  master -> slave  data1 (bit7 ignored)
//   msg_byte2  master -> slave  data2 (bit7 ignored, unused for 2-byte messages)
interface midi_encoder_if;
  logic       msg_valid;
  logic       msg_ready;
  logic [7:0] msg_byte0;
  logic [7:0] msg_byte1;
  logic [7:0] msg_byte2;

  modport master (
    output msg_valid,
    output msg_byte0,
    output msg_byte1,
    output msg_byte2,
    input  msg_ready
  );

  modport slave (
    input  msg_valid,
    input  msg_byte0,
    input  msg_byte1,
    input  msg_byte2,
    output msg_ready
  );
endinterface

// File: rtl/midi_encoder.sv
// MIDI OUT transmitter: takes one complete MIDI message per handshake and serialises it as
// 8N1 UART (LSB first), bytes back-to-back, with optional running-status compression.
//   clk_i       system clock
//   reset_i     synchronous, active-high reset
//   msg_if      message handshake (slave side)
//   midi_tx_o   serial MIDI OUT, idle high, driven from a register
//   busy_o      high from accept until the last stop bit completes
//   msg_done_o  one-cycle pulse after the last stop bit of a message
module midi_encoder #(
  parameter int unsigned CLKS_PER_BIT   = 1536,
  parameter bit          RUNNING_STATUS = 1'b0
) (
  input  logic           clk_i,
  input  logic           reset_i,
  midi_encoder_if.slave  msg_if,
  output logic           midi_tx_o,
  output logic           busy_o,
  output logic           msg_done_o
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StStart, StData, StStop, StDone} state_e;

  state_e          state_q, state_d;
  logic [7:0]      byte0_q, byte0_d;
  logic [7:0]      byte1_q, byte1_d;
  logic [7:0]      byte2_q, byte2_d;
  logic [1:0]      idx_q, idx_d;
  logic [1:0]      last_idx_q, last_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [2:0]      bit_q, bit_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tx_q, tx_d;
  logic [7:0]      last_status_q, last_status_d;

  logic [7:0] in_b0;
  logic       accept, is_chan, is_sys_common, two_byte, skip_status;

  assign in_b0         = msg_if.msg_byte0;
  assign accept        = msg_if.msg_valid && (state_q == StIdle);
  assign is_chan       = (in_b0 >= 8'h80) && (in_b0 <= 8'hEF);
  assign is_sys_common = (in_b0 >= 8'hF0) && (in_b0 <= 8'hF7);
  assign two_byte      = (in_b0[7:4] == 4'hC) || (in_b0[7:4] == 4'hD) || (in_b0[7:4] == 4'hF);
  assign skip_status   = RUNNING_STATUS && is_chan && (in_b0 == last_status_q);

  always_comb begin
    state_d       = state_q;
    byte0_d       = byte0_q;
    byte1_d       = byte1_q;
    byte2_d       = byte2_q;
    idx_d         = idx_q;
    last_idx_d    = last_idx_q;
    shift_d       = shift_q;
    bit_d         = bit_q;
    cnt_d         = cnt_q;
    tx_d          = tx_q;
    last_status_d = last_status_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          byte0_d    = in_b0;
          byte1_d    = {1'b0, msg_if.msg_byte1[6:0]};
          byte2_d    = {1'b0, msg_if.msg_byte2[6:0]};
          idx_d      = skip_status ? 2'd1 : 2'd0;
          last_idx_d = two_byte ? 2'd1 : 2'd2;
          if (!in_b0[7]) begin
            // Not a status byte: drop the message, line stays idle.
            state_d = StDone;
          end else begin
            // The start bit goes out in the very next cycle; LOAD is its first cycle.
            state_d = StLoad;
            tx_d    = 1'b0;
            cnt_d   = '0;
            if (is_chan) begin
              last_status_d = in_b0;
            end else if (is_sys_common) begin
              last_status_d = 8'h00;
            end
          end
        end
      end
      StLoad: begin
        case (idx_q)
          2'd0:    shift_d = byte0_q;
          2'd1:    shift_d = byte1_q;
          default: shift_d = byte2_q;
        endcase
        cnt_d   = CntW'(1);
        state_d = StStart;
      end
      StStart: begin
        if (cnt_q == CntMax) begin
          cnt_d   = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          state_d = StData;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (cnt_q == CntMax) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = StStop;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStop: begin
        if (cnt_q == CntMax) begin
          cnt_d = '0;
          if (idx_q == last_idx_q) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + 2'd1;
            tx_d    = 1'b0;
            state_d = StLoad;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= StIdle;
      byte0_q       <= '0;
      byte1_q       <= '0;
      byte2_q       <= '0;
      idx_q         <= '0;
      last_idx_q    <= '0;
      shift_q       <= '0;
      bit_q         <= '0;
      cnt_q         <= '0;
      tx_q          <= 1'b1;
      last_status_q <= '0;
    end else begin
      state_q       <= state_d;
      byte0_q       <= byte0_d;
      byte1_q       <= byte1_d;
      byte2_q       <= byte2_d;
      idx_q         <= idx_d;
      last_idx_q    <= last_idx_d;
      shift_q       <= shift_d;
      bit_q         <= bit_d;
      cnt_q         <= cnt_d;
      tx_q          <= tx_d;
      last_status_q <= last_status_d;
    end
  end

  assign msg_if.msg_ready = (state_q == StIdle);
  assign busy_o           = (state_q != StIdle);
  assign msg_done_o       = (state_q == StDone);
  assign midi_tx_o        = tx_q;

endmodule

// File: tb/tb_midi_encoder.sv
// Bench for midi_encoder: three instances (RS=0, RS=1, full-rate timing) share one clock and
// reset. Expected line waveforms come from a message-level model of MIDI byte selection.
module tb_midi_encoder;
  localparam int unsigned Cpb     = 4;
  localparam int unsigned CpbLong = 1536;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] tx, busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] ls_m[3];

  always #5 clk = ~clk;

  midi_encoder_if bus0();
  midi_encoder_if bus1();
  midi_encoder_if bus2();

  midi_encoder #(.CLKS_PER_BIT(Cpb), .RUNNING_STATUS(1'b0)) u_dut0 (
    .clk_i(clk), .reset_i(reset), .msg_if(bus0.slave),
    .midi_tx_o(tx[0]), .busy_o(busy[0]), .msg_done_o(done[0])
  );
  midi_encoder #(.CLKS_PER_BIT(Cpb), .RUNNING_STATUS(1'b1)) u_dut1 (
    .clk_i(clk), .reset_i(reset), .msg_if(bus1.slave),
    .midi_tx_o(tx[1]), .busy_o(busy[1]), .msg_done_o(done[1])
  );
  midi_encoder #(.CLKS_PER_BIT(CpbLong), .RUNNING_STATUS(1'b0)) u_dut2 (
    .clk_i(clk), .reset_i(reset), .msg_if(bus2.slave),
    .midi_tx_o(tx[2]), .busy_o(busy[2]), .msg_done_o(done[2])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input int d, input logic v, input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] b2);
    case (d)
      0: begin
        bus0.msg_valid = v; bus0.msg_byte0 = b0; bus0.msg_byte1 = b1; bus0.msg_byte2 = b2;
      end
      1: begin
        bus1.msg_valid = v; bus1.msg_byte0 = b0; bus1.msg_byte1 = b1; bus1.msg_byte2 = b2;
      end
      default: begin
        bus2.msg_valid = v; bus2.msg_byte0 = b0; bus2.msg_byte1 = b1; bus2.msg_byte2 = b2;
      end
    endcase
  endtask

  function automatic logic get_ready(input int d);
    case (d)
      0:       return bus0.msg_ready;
      1:       return bus1.msg_ready;
      default: return bus2.msg_ready;
    endcase
  endfunction

  function automatic int cpb_of(input int d);
    return (d == 2) ? CpbLong : Cpb;
  endfunction

  // Message-level model: which bytes appear on the line, and running-status bookkeeping.
  task automatic build_expected(input int d, input logic [7:0] b0, input logic [7:0] b1,
                                input logic [7:0] b2);
    logic chan;
    exp_q.delete();
    if (b0 < 8'h80) return;
    chan = (b0 >= 8'h80) && (b0 <= 8'hEF);
    if (!((d == 1) && chan && (b0 == ls_m[d]))) exp_q.push_back(b0);
    exp_q.push_back(b1 & 8'h7F);
    if (!(b0[7:4] == 4'hC || b0[7:4] == 4'hD || b0[7:4] == 4'hF)) exp_q.push_back(b2 & 8'h7F);
    if (chan) ls_m[d] = b0;
    else if (b0 >= 8'hF0 && b0 <= 8'hF7) ls_m[d] = 8'h00;
  endtask

  // Expected line level k cycles after the first start-bit cycle.
  function automatic logic exp_line(input int k, input int cpb);
    int         bi;
    int         pos;
    logic [7:0] b;
    bi  = k / (10 * cpb);
    pos = (k / cpb) % 10;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    b = exp_q[bi];
    return b[pos-1];
  endfunction

  task automatic offer(input int d, input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] b2);
    int w = 0;
    @(negedge clk);
    while (!get_ready(d) && w < 1000) begin
      @(negedge clk);
      w++;
    end
    check_eq("ready_before_accept", get_ready(d), 1);
    drive(d, 1'b1, b0, b1, b2);
    build_expected(d, b0, b1, b2);
    @(posedge clk);
  endtask

  // Observe one message from the cycle after accept through msg_done. With hold set, keep
  // msg_valid high with junk during the transfer and present the next message at msg_done.
  task automatic collect(input int d, input bit hold, input logic [7:0] nb0,
                         input logic [7:0] nb1, input logic [7:0] nb2);
    int   cpb      = cpb_of(d);
    int   len      = exp_q.size() * 10 * cpb;
    int   k        = 0;
    int   bad      = 0;
    int   busy_bad = 0;
    int   done_at  = -1;
    logic t;
    while (k <= len + 4) begin
      @(negedge clk);
      t = tx[d];
      if (!busy[d] || get_ready(d)) busy_bad++;
      if (done[d]) begin
        check_eq("tx_idle_at_done", t, 1);
        done_at = k;
        break;
      end
      if (k < len) begin
        if (t !== exp_line(k, cpb)) bad++;
      end else if (t !== 1'b1) begin
        bad++;
      end
      if (hold) drive(d, 1'b1, 8'($urandom), 8'($urandom), 8'($urandom));
      else drive(d, 1'b0, 8'h00, 8'h00, 8'h00);
      k++;
    end
    check_eq("duration", done_at, len);
    check_eq("wave_bit_errors", bad, 0);
    check_eq("busy_ready_during_msg", busy_bad, 0);
    if (hold) drive(d, 1'b1, nb0, nb1, nb2);
    @(negedge clk);
    check_eq("ready_after_done", get_ready(d), 1);
    check_eq("done_single_pulse", done[d], 0);
  endtask

  task automatic send(input int d, input logic [7:0] b0, input logic [7:0] b1,
                      input logic [7:0] b2);
    offer(d, b0, b1, b2);
    collect(d, 1'b0, 8'h00, 8'h00, 8'h00);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] pool[8];
    logic [7:0] b0;
    int         dcount;
    pool = '{8'h90, 8'h91, 8'hC5, 8'hF8, 8'hF0, 8'hB0, 8'h3C, 8'hE0};
    for (int i = 0; i < 3; i++) begin
      ls_m[i] = 8'h00;
      drive(i, 1'b0, 8'h00, 8'h00, 8'h00);
    end
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check_eq("reset_tx", tx[i], 1);
      check_eq("reset_ready", get_ready(i), 1);
      check_eq("reset_busy", busy[i], 0);
      check_eq("reset_done", done[i], 0);
    end
    reset = 1'b0;

    // Note-on, program change (byte2 never sent), dropped non-status byte.
    send(0, 8'h90, 8'h3C, 8'h64);
    send(0, 8'hC5, 8'h07, 8'h55);
    send(0, 8'h45, 8'h12, 8'h34);

    // Running-status sequence.
    send(1, 8'h90, 8'h3C, 8'h64);
    send(1, 8'h90, 8'h40, 8'h7F);
    send(1, 8'hF8, 8'h00, 8'h00);
    send(1, 8'h90, 8'h3C, 8'h00);
    send(1, 8'hF0, 8'h7F, 8'h11);
    send(1, 8'h90, 8'h3C, 8'h00);

    // msg_valid held high with changing data; the queued message is taken right after done.
    offer(0, 8'h90, 8'h3C, 8'h64);
    collect(0, 1'b1, 8'hC2, 8'h05, 8'h00);
    build_expected(0, 8'hC2, 8'h05, 8'h00);
    @(posedge clk);
    collect(0, 1'b0, 8'h00, 8'h00, 8'h00);

    // Reset during data bit 3 of the second byte; DUT1 holds last_status 0x90 beforehand.
    send(1, 8'h90, 8'h3C, 8'h64);
    offer(0, 8'h90, 8'h11, 8'h22);
    #1 drive(0, 1'b0, 8'h00, 8'h00, 8'h00);
    repeat (10 * Cpb + 4 * Cpb + 2) @(negedge clk);
    check_eq("pre_reset_busy", busy[0], 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_eq("midreset_tx", tx[0], 1);
    check_eq("midreset_ready", get_ready(0), 1);
    check_eq("midreset_busy", busy[0], 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) ls_m[i] = 8'h00;
    dcount = 0;
    repeat (30) begin
      @(negedge clk);
      if (done[0]) dcount++;
    end
    check_eq("no_done_after_reset", dcount, 0);
    send(1, 8'h90, 8'h3C, 8'h00);

    // Randomised messages on both compact-timing instances.
    for (int i = 0; i < 40; i++) begin
      b0 = ($urandom_range(0, 3) == 0) ? 8'($urandom) : pool[$urandom_range(0, 7)];
      send(i % 2, b0, 8'($urandom), 8'($urandom));
    end

    // Full-rate bit timing with data1 bit7 set.
    send(2, 8'h90, 8'hFF, 8'h64);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
